// File: rtl/shift_left_seq.sv
// shift_left_seq: iterative logical left shifter for the rotation datapath.
// The operand is captured on the accepting edge and shifted one bit per clock.
// Any '1' that leaves the MSB is accumulated into an overflow flag, which is
// published together with the result at completion.
// Handshake: start (sampled only while idle), busy, and a one-cycle done pulse.
module shift_left_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [CNT_W-1:0] shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_ovf_q, acc_ovf_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // Next-state and datapath update; every target holds unless its state says otherwise.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    acc_ovf_d = acc_ovf_q;
    out_d     = out_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d      = a;
          cnt_d     = shamt;
          acc_ovf_d = 1'b0;
          // A zero shift skips SHIFT entirely so the counter can never wrap.
          state_d   = (shamt != CNT_ZERO) ? SHIFT : FINISH;
        end
      end
      SHIFT: begin
        sr_d      = {sr_q[WIDTH-2:0], 1'b0};
        acc_ovf_d = acc_ovf_q | sr_q[WIDTH-1];
        cnt_d     = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        out_d   = sr_q;
        ovf_d   = acc_ovf_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // busy is registered from the upcoming state so it drops in the done cycle.
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      acc_ovf_q <= 1'b0;
      out_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      acc_ovf_q <= acc_ovf_d;
      out_q     <= out_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;
  assign ovf  = ovf_q;

endmodule
